a2d_req_arbiter: RTL and testbench
==================================

// Module: a2d_req_arbiter
// PURPOSE
//  Shares the single A2D_intf SPI converter among NUM_REQ requesters (slide-pot scanner,
//  battery monitor, spare). Round-robin arbitration; issues the strt_cnv/chnnl handshake
//  on the winner's behalf, captures res on cnv_cmplt and returns it with a done pulse.
//  Sits between the requesters and A2D_intf; it is the only block that drives A2D_intf.
// PARAMETERS
//  NUM_REQ     4     number of requesters (2..8)
//  CH_W        3     A2D channel select width
//  RES_W       12    conversion result width
//  TIMEOUT_CYC 4096  watchdog limit in clk cycles (used only with A2D_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1             system clock, all state on posedge
//  rst        in   1             asynchronous, active-high reset
//  req        in   NUM_REQ       per-requester conversion request, level
//  req_chnnl  in   NUM_REQ*CH_W  channel per requester; requester i owns bits [i*CH_W +: CH_W]
//  gnt        out  NUM_REQ       one-hot grant, high from ISSUE through DONE
//  done       out  NUM_REQ       one-cycle pulse to the granted requester; res_out valid that cycle
//  res_out    out  RES_W         captured conversion result, held until the next capture
//  err        out  1             high together with done on watchdog abort (tied 0 without macro)
//  strt_cnv   out  1             to A2D_intf: start conversion, one-cycle pulse
//  chnnl      out  CH_W          to A2D_intf: channel select, stable from ISSUE through DONE
//  cnv_cmplt  in   1             from A2D_intf: conversion complete
//  res        in   RES_W         from A2D_intf: result, valid while cnv_cmplt is high
// BEHAVIOUR
//  Reset: state=IDLE; gnt, done, err, strt_cnv, chnnl, res_out = 0; ptr = NUM_REQ-1.
//  All outputs are registered. FSM states IDLE, ISSUE, WAIT, DONE:
//   IDLE : if |req, winner = first set req scanning ptr+1, ptr+2, ... (mod NUM_REQ);
//          latch idx, gnt<=onehot(idx), chnnl<=req_chnnl[idx]; -> ISSUE. Else stay.
//   ISSUE: strt_cnv=1 for this cycle only; -> WAIT.
//   WAIT : on cnv_cmplt: res_out<=res; -> DONE. Otherwise stay.
//   DONE : done[idx]=1 for one cycle; ptr<=idx; -> IDLE, with gnt cleared on entry to IDLE.
//  Latency: req seen in IDLE at cycle N -> gnt/chnnl/strt_cnv at N+1. cnv_cmplt at cycle M
//   -> res_out/done at M+1 -> gnt low at M+2. Minimum req-to-done is 3 cycles.
//  req and req_chnnl are sampled only in IDLE. A req dropped after grant does not abort;
//   the conversion completes and done still pulses.
//  A requester that holds req through DONE is re-arbitrated behind the other requesters
//   (it holds the lowest priority). No starvation; worst-case wait is NUM_REQ-1 conversions.
//  cnv_cmplt in IDLE or ISSUE is ignored. cnv_cmplt in the ISSUE cycle is not counted
//   as completion.
//  Single requester: back-to-back conversions with one IDLE cycle between them.
//  Reset during WAIT: everything returns to reset values and no done is issued. A2D_intf
//   shares the same reset.
// CONFIGURATION
//  A2D_ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT.
//   - If cnv_cmplt is absent for TIMEOUT_CYC cycles in WAIT -> DONE with err=1 and
//     res_out = {RES_W{1'b1}}; done pulses as normal.
//   - If cnv_cmplt and the timeout occur in the same cycle, cnv_cmplt wins (err=0).
//  A2D_ARB_TIMEOUT_EN undefined:
//   - No counter. WAIT lasts until cnv_cmplt. err is tied 0.
// TESTING
//  1 Reset, then req=4'b0001, ch0=3'd2, cnv_cmplt 10 cycles after strt_cnv, res=12'hABC
//    -> gnt=0001, chnnl=2, one strt_cnv pulse, done[0] with res_out=ABC.
//  2 req=4'b1111 held with channels 0,1,2,7 -> grant order 0,1,2,3,0...; chnnl follows
//    0,1,2,7; each done has the matching res.
//  3 req=4'b0101 held; req0 re-requests after its done -> req2 served before req0 again.
//  4 cnv_cmplt pulsed in IDLE and in ISSUE -> no capture and no done; completion only
//    from WAIT.
//  5 rst asserted in WAIT -> all outputs 0 on the next edge; after release req1 is
//    granted before req2 (ptr reset).
//  6 [A2D_ARB_TIMEOUT_EN, TIMEOUT_CYC=16] no cnv_cmplt -> done and err at WAIT+16,
//    res_out=FFF; repeat with cnv_cmplt on cycle 16 -> err=0.

Source files
------------

// File: rtl/a2d_req_arbiter.sv
// a2d_req_arbiter
// Round-robin arbiter that shares the single A2D_intf converter among NUM_REQ
// requesters. It issues strt_cnv/chnnl for the winner, captures res on cnv_cmplt
// and hands the result back with a one-cycle done pulse.
// Optional watchdog: define A2D_ARB_TIMEOUT_EN to abort a conversion that sees no
// cnv_cmplt within TIMEOUT_CYC cycles of WAIT (done with err=1, res_out all ones).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate over req, winner latched on exit
// ISSUE | grant and channel presented, strt_cnv high for this cycle
// WAIT  | conversion in progress, waiting for cnv_cmplt (or watchdog)
// DONE  | result valid, done pulsed to the winner, pointer advanced
module a2d_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CH_W        = 3,
    parameter int RES_W       = 12,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*CH_W-1:0] req_chnnl,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [RES_W-1:0]        res_out,
    output logic                    err,
    output logic                    strt_cnv,
    output logic [CH_W-1:0]         chnnl,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("a2d_req_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
    logic [RES_W-1:0]   res_out_nxt;
    logic               strt_cnv_nxt;
    logic [CH_W-1:0]    chnnl_nxt;
    logic [IDX_W:0]     pick;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [CH_W-1:0]    ch_sel;

    // Scan from farthest to nearest so the requester right after p ends up winning;
    // p itself is visited first and therefore has the lowest priority.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
        logic [IDX_W:0] sel;
        int             j;
        sel = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(p) + k) % NUM_REQ;
            if (r[IDX_W'(j)]) sel = {1'b1, IDX_W'(j)};
        end
        return sel;
    endfunction

    assign pick    = rr_pick(req, ptr);
    assign win_vld = pick[IDX_W];
    assign win_idx = pick[IDX_W-1:0];

    // Channel of the current winner.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) ch_sel = req_chnnl[i*CH_W +: CH_W];
        end
    end

`ifdef A2D_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    logic [TMR_W-1:0] tmr;
    logic             err_nxt;

    // Watchdog down-counter: loaded during ISSUE, counts down through WAIT; zero means expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr <= '0;
        else if (state == ISSUE) tmr <= TMR_W'(TIMEOUT_CYC - 1);
        else if (state == WAIT && tmr != '0) tmr <= tmr - TMR_W'(1);
    end

    // Abort flag, registered alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err_nxt;
    end
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        idx_nxt      = idx;
        gnt_nxt      = gnt;
        done_nxt     = '0;
        strt_cnv_nxt = 1'b0;
        chnnl_nxt    = chnnl;
        res_out_nxt  = res_out;
`ifdef A2D_ARB_TIMEOUT_EN
        err_nxt      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (win_vld) begin
                    idx_nxt      = win_idx;
                    gnt_nxt      = NUM_REQ'(1) << win_idx;
                    chnnl_nxt    = ch_sel;
                    strt_cnv_nxt = 1'b1;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnv_cmplt) begin
                    res_out_nxt = res;
                    done_nxt    = gnt;
                    state_nxt   = DONE;
                end
`ifdef A2D_ARB_TIMEOUT_EN
                else if (tmr == '0) begin
                    res_out_nxt = '1;
                    done_nxt    = gnt;
                    err_nxt     = 1'b1;
                    state_nxt   = DONE;
                end
`endif
            end
            DONE: begin
                ptr_nxt   = idx;
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_REQ - 1);
            idx      <= '0;
            gnt      <= '0;
            done     <= '0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            res_out  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx      <= idx_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            strt_cnv <= strt_cnv_nxt;
            chnnl    <= chnnl_nxt;
            res_out  <= res_out_nxt;
        end
    end

endmodule

// File: tb/tb_a2d_req_arbiter.sv
// Testbench for a2d_req_arbiter: randomized requests checked against a round-robin
// reference model; the A2D_intf side is emulated by the bench.
module tb_a2d_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CH_W    = 3;
    localparam int RES_W   = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*CH_W-1:0] req_chnnl;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      done;
    logic [RES_W-1:0]        res_out;
    logic                    err;
    logic                    strt_cnv;
    logic [CH_W-1:0]         chnnl;
    logic                    cnv_cmplt;
    logic [RES_W-1:0]        res;

    int total = 0;
    int bad   = 0;

    // reference model state: last served requester and last delivered result
    int               last_win;
    logic [RES_W-1:0] exp_res;

    a2d_req_arbiter #(
        .NUM_REQ(NUM_REQ), .CH_W(CH_W), .RES_W(RES_W), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl),
        .gnt(gnt), .done(done), .res_out(res_out), .err(err),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
    );

    always #5 clk = ~clk;

    // Round-robin rule: first requester found walking forward from the last one served.
    function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int last);
        for (int off = 1; off <= NUM_REQ; off++) begin
            int i;
            i = (last + off) % NUM_REQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // One full conversion for whichever requester the model says wins next.
    task automatic do_conv(input int delay, input bit pulse_issue, input bit drop_req,
                           input logic [RES_W-1:0] r);
        int                 w;
        int                 win;
        logic [NUM_REQ-1:0] eg;
        logic [CH_W-1:0]    ec;
        win = rr_model(req, last_win);
        eg  = NUM_REQ'(1) << win;
        ec  = req_chnnl[win*CH_W +: CH_W];
        w   = 0;
        do begin
            @(negedge clk);
            w++;
        end while (strt_cnv !== 1'b1 && w < 20);
        total++;
        if (strt_cnv !== 1'b1) begin
            $display("FAIL strt_wait: strt_cnv=%0b after %0d cycles, want 1", strt_cnv, w);
            bad++;
            return;
        end
        total++;
        if (w != 1) begin $display("FAIL grant_latency: got %0d cycles want 1", w); bad++; end
        total++;
        if (gnt !== eg) begin $display("FAIL gnt: got %b want %b", gnt, eg); bad++; end
        total++;
        if (chnnl !== ec) begin $display("FAIL chnnl: got %0d want %0d", chnnl, ec); bad++; end
        total++;
        if (done !== '0) begin $display("FAIL done_in_issue: got %b want 0", done); bad++; end
        if (pulse_issue) begin cnv_cmplt = 1'b1; res = ~r; end
        if (drop_req) req = '0;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        total++;
        if (strt_cnv !== 1'b0) begin $display("FAIL strt_pulse: got %0b want 0", strt_cnv); bad++; end
        total++;
        if (done !== '0 || res_out !== exp_res) begin
            $display("FAIL early_capture: done=%b res_out=%h want done=0 res_out=%h", done, res_out, exp_res);
            bad++;
        end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            total++;
            if (done !== '0 || strt_cnv !== 1'b0 || gnt !== eg || chnnl !== ec) begin
                $display("FAIL wait_hold: done=%b strt=%0b gnt=%b chnnl=%0d want 0 0 %b %0d",
                         done, strt_cnv, gnt, chnnl, eg, ec);
                bad++;
            end
        end
        cnv_cmplt = 1'b1;
        res       = r;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = RES_W'($urandom);
        exp_res   = r;
        last_win  = win;
        total++;
        if (done !== eg) begin $display("FAIL done: got %b want %b", done, eg); bad++; end
        total++;
        if (res_out !== r) begin $display("FAIL res_out: got %h want %h", res_out, r); bad++; end
        total++;
        if (err !== 1'b0 || gnt !== eg || chnnl !== ec) begin
            $display("FAIL done_cycle: err=%0b gnt=%b chnnl=%0d want 0 %b %0d", err, gnt, chnnl, eg, ec);
            bad++;
        end
        @(negedge clk);
        total++;
        if (done !== '0 || gnt !== '0 || res_out !== r) begin
            $display("FAIL after_done: done=%b gnt=%b res_out=%h want 0 0 %h", done, gnt, res_out, r);
            bad++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_chnnl = '0; cnv_cmplt = 1'b0; res = '0;
        last_win = NUM_REQ - 1;
        exp_res  = '0;
        repeat (3) @(negedge clk);
        total++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || strt_cnv !== 1'b0 ||
            chnnl !== '0 || res_out !== '0) begin
            $display("FAIL reset_outputs: gnt=%b done=%b err=%0b strt=%0b chnnl=%0d res_out=%h want all 0",
                     gnt, done, err, strt_cnv, chnnl, res_out);
            bad++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== '0 || strt_cnv !== 1'b0) begin
            $display("FAIL idle_no_req: gnt=%b strt=%0b want 0 0", gnt, strt_cnv);
            bad++;
        end
    endtask

    task automatic test_single;
        req       = 4'b0001;
        req_chnnl = 12'h002;
        do_conv(9, 1'b0, 1'b0, 12'hABC);
        do_conv(0, 1'b0, 1'b0, RES_W'($urandom));
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_win  = NUM_REQ - 1;
        exp_res   = '0;
        req       = 4'b1111;
        req_chnnl = {3'd7, 3'd2, 3'd1, 3'd0};
        for (int n = 0; n < 6; n++) do_conv($urandom_range(0, 4), 1'b0, 1'b0, RES_W'($urandom));
        req = '0;
    endtask

    task automatic test_hold_two;
        req       = 4'b0101;
        req_chnnl = RES_W'($urandom);
        for (int n = 0; n < 4; n++) do_conv($urandom_range(0, 3), 1'b0, 1'b0, RES_W'($urandom));
        req = '0;
    endtask

    task automatic test_stray_cmplt;
        for (int n = 0; n < 3; n++) begin
            cnv_cmplt = 1'b1;
            res       = RES_W'($urandom);
            @(negedge clk);
            total++;
            if (done !== '0 || gnt !== '0 || strt_cnv !== 1'b0 || res_out !== exp_res) begin
                $display("FAIL idle_cmplt: done=%b gnt=%b strt=%0b res_out=%h want 0 0 0 %h",
                         done, gnt, strt_cnv, res_out, exp_res);
                bad++;
            end
        end
        cnv_cmplt = 1'b0;
        req       = 4'b0100;
        req_chnnl = RES_W'($urandom);
        do_conv(2, 1'b1, 1'b0, RES_W'($urandom));
        req = '0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            req       = NUM_REQ'($urandom_range(1, 15));
            req_chnnl = RES_W'($urandom);
            do_conv($urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), RES_W'($urandom));
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait;
        int w;
        req       = 4'b0110;
        req_chnnl = RES_W'($urandom);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (strt_cnv !== 1'b1 && w < 20);
        total++;
        if (strt_cnv !== 1'b1) begin
            $display("FAIL rst_wait_strt: strt_cnv=%0b want 1", strt_cnv);
            bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || strt_cnv !== 1'b0 ||
            chnnl !== '0 || res_out !== '0) begin
            $display("FAIL reset_in_wait: gnt=%b done=%b err=%0b strt=%0b chnnl=%0d res_out=%h want all 0",
                     gnt, done, err, strt_cnv, chnnl, res_out);
            bad++;
        end
        @(negedge clk);
        total++;
        if (done !== '0) begin $display("FAIL reset_no_done: got %b want 0", done); bad++; end
        rst      = 1'b0;
        last_win = NUM_REQ - 1;
        exp_res  = '0;
        do_conv(1, 1'b0, 1'b0, RES_W'($urandom));
        do_conv(1, 1'b0, 1'b0, RES_W'($urandom));
        req = '0;
        @(negedge clk);
    endtask

`ifdef A2D_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int                 w;
        int                 win;
        logic [NUM_REQ-1:0] eg;
        req       = 4'b1000;
        req_chnnl = RES_W'($urandom);
        win = rr_model(req, last_win);
        eg  = NUM_REQ'(1) << win;
        w   = 0;
        do begin
            @(negedge clk);
            w++;
        end while (strt_cnv !== 1'b1 && w < 20);
        req = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if (done !== '0 || err !== 1'b0) begin
                $display("FAIL early_timeout: cycle %0d done=%b err=%0b want 0 0", k, done, err);
                bad++;
            end
        end
        @(negedge clk);
        total++;
        if (done !== eg || err !== 1'b1 || res_out !== 12'hFFF) begin
            $display("FAIL timeout_abort: done=%b err=%0b res_out=%h want %b 1 fff", done, err, res_out, eg);
            bad++;
        end
        exp_res  = 12'hFFF;
        last_win = win;
        @(negedge clk);
        total++;
        if (gnt !== '0 || err !== 1'b0) begin
            $display("FAIL timeout_release: gnt=%b err=%0b want 0 0", gnt, err);
            bad++;
        end
        req = 4'b1000;
        do_conv(15, 1'b0, 1'b1, RES_W'($urandom));
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_hold_two;
        test_stray_cmplt;
        test_random;
        test_reset_in_wait;
`ifdef A2D_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
